// File: rtl/spi_slave_axi_mem_pkg.sv
// Shared constants and types for the AXI4 word memory behind the SPI slave plug.
// Optional feature macro: SPI_SLAVE_AXI_MEM_DECERR_EN (upper-address decode errors).
package spi_slave_axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Both FSM states bundled for observation from outside the block.
    typedef struct packed {
        wr_state_e wr_state;
        rd_state_e rd_state;
    } dbg_state_t;

endpackage

// File: rtl/spi_slave_axi_mem_array.sv
// Register-based word memory: one byte-enabled write port, one combinational read port.
// Contents are deliberately not reset.
module spi_slave_axi_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 256,
    localparam int IDX_W     = $clog2(WORDS),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Byte-lane writes; lanes with a cleared strobe keep their old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read is asynchronous, so a same-cycle write is only visible next cycle.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/spi_slave_axi_mem.sv
// AXI4 slave word memory with independent write (AW->W->B) and read (AR->R) FSMs.
// Optional feature macro: SPI_SLAVE_AXI_MEM_DECERR_EN -- when defined, nonzero address
// bits above the memory range return DECERR and writes to them are dropped.
// Handshake rule: a transfer happens on the rising edge where valid and ready are both high;
// valid never waits for ready, and payload is held stable while valid && !ready.
module spi_slave_axi_mem
    import spi_slave_axi_mem_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int MEM_WORDS      = 256
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic                        axi_slave_aw_valid,
    output logic                        axi_slave_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
    input  logic [7:0]                  axi_slave_aw_len,
    input  logic [2:0]                  axi_slave_aw_size,
    input  logic [1:0]                  axi_slave_aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
    input  logic [2:0]                  axi_slave_aw_prot,
    input  logic [3:0]                  axi_slave_aw_region,
    input  logic                        axi_slave_aw_lock,
    input  logic [3:0]                  axi_slave_aw_cache,
    input  logic [3:0]                  axi_slave_aw_qos,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
    input  logic                        axi_slave_w_valid,
    output logic                        axi_slave_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
    input  logic                        axi_slave_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
    output logic                        axi_slave_b_valid,
    input  logic                        axi_slave_b_ready,
    output logic [1:0]                  axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
    input  logic                        axi_slave_ar_valid,
    output logic                        axi_slave_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
    input  logic [7:0]                  axi_slave_ar_len,
    input  logic [2:0]                  axi_slave_ar_size,
    input  logic [1:0]                  axi_slave_ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
    input  logic [2:0]                  axi_slave_ar_prot,
    input  logic [3:0]                  axi_slave_ar_region,
    input  logic                        axi_slave_ar_lock,
    input  logic [3:0]                  axi_slave_ar_cache,
    input  logic [3:0]                  axi_slave_ar_qos,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
    output logic                        axi_slave_r_valid,
    input  logic                        axi_slave_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
    output logic [1:0]                  axi_slave_r_resp,
    output logic                        axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user,
    output dbg_state_t                  dbg_state
);

    localparam int OFF_W = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int TOP_W = OFF_W + IDX_W;

    wr_state_e                   wr_state, wr_next;
    logic [IDX_W-1:0]            w_idx;
    logic [7:0]                  w_len, w_cnt;
    logic                        w_fixed, w_err;
    logic [AXI_ID_WIDTH-1:0]     w_id;
    logic                        w_dec;
    rd_state_e                   rd_state, rd_next;
    logic [IDX_W-1:0]            r_idx;
    logic [7:0]                  r_len, r_cnt;
    logic                        r_fixed;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic                        r_dec;
    logic [AXI_DATA_WIDTH-1:0]   mem_rdata;
    logic                        aw_hs, w_hs, ar_hs, r_hs, w_cnt_end, mem_we;

    assign aw_hs     = axi_slave_aw_valid && axi_slave_aw_ready;
    assign w_hs      = axi_slave_w_valid && axi_slave_w_ready;
    assign ar_hs     = axi_slave_ar_valid && axi_slave_ar_ready;
    assign r_hs      = axi_slave_r_valid && axi_slave_r_ready;
    assign w_cnt_end = (w_cnt == w_len);
    assign mem_we    = w_hs && !w_dec;

    assign axi_slave_b_user = '0;
    assign axi_slave_r_user = '0;
    assign dbg_state        = '{wr_state: wr_state, rd_state: rd_state};

    // State registers for both channels; reset aborts any transfer in flight.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Write-side burst context: captured at AW, stepped on every accepted W beat.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
            w_id    <= '0;
            w_dec   <= 1'b0;
        end else if (aw_hs) begin
            w_idx   <= axi_slave_aw_addr[OFF_W +: IDX_W];
            w_len   <= axi_slave_aw_len;
            w_cnt   <= '0;
            w_fixed <= (axi_slave_aw_burst == BURST_FIXED);
            w_err   <= 1'b0;
            w_id    <= axi_slave_aw_id;
`ifdef SPI_SLAVE_AXI_MEM_DECERR_EN
            w_dec   <= (axi_slave_aw_addr[AXI_ADDR_WIDTH-1:TOP_W] != '0);
`else
            w_dec   <= 1'b0;
`endif
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) begin
                w_idx <= w_idx + IDX_W'(1);
            end
            // A w_last that disagrees with the beat count marks the burst as malformed.
            w_err <= w_err | (axi_slave_w_last != w_cnt_end);
        end
    end

    // Read-side burst context: captured at AR, stepped on every accepted R beat.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_id    <= '0;
            r_dec   <= 1'b0;
        end else if (ar_hs) begin
            r_idx   <= axi_slave_ar_addr[OFF_W +: IDX_W];
            r_len   <= axi_slave_ar_len;
            r_cnt   <= '0;
            r_fixed <= (axi_slave_ar_burst == BURST_FIXED);
            r_id    <= axi_slave_ar_id;
`ifdef SPI_SLAVE_AXI_MEM_DECERR_EN
            r_dec   <= (axi_slave_ar_addr[AXI_ADDR_WIDTH-1:TOP_W] != '0);
`else
            r_dec   <= 1'b0;
`endif
        end else if (r_hs) begin
            r_cnt <= r_cnt + 8'd1;
            if (!r_fixed) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Write FSM next state and channel outputs.
    always_comb begin
        wr_next            = wr_state;
        axi_slave_aw_ready = 1'b0;
        axi_slave_w_ready  = 1'b0;
        axi_slave_b_valid  = 1'b0;
        axi_slave_b_resp   = RESP_OKAY;
        axi_slave_b_id     = w_id;
        unique case (wr_state)
            W_IDLE: begin
                axi_slave_aw_ready = 1'b1;
                if (axi_slave_aw_valid) wr_next = W_DATA;
            end
            W_DATA: begin
                axi_slave_w_ready = 1'b1;
                if (axi_slave_w_valid && (axi_slave_w_last || w_cnt_end)) wr_next = W_RESP;
            end
            W_RESP: begin
                axi_slave_b_valid = 1'b1;
                if (w_dec)      axi_slave_b_resp = RESP_DECERR;
                else if (w_err) axi_slave_b_resp = RESP_SLVERR;
                if (axi_slave_b_ready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Read FSM next state and channel outputs; data comes straight from the array.
    always_comb begin
        rd_next            = rd_state;
        axi_slave_ar_ready = 1'b0;
        axi_slave_r_valid  = 1'b0;
        axi_slave_r_last   = 1'b0;
        axi_slave_r_resp   = RESP_OKAY;
        axi_slave_r_id     = r_id;
        axi_slave_r_data   = r_dec ? '0 : mem_rdata;
        unique case (rd_state)
            R_IDLE: begin
                axi_slave_ar_ready = 1'b1;
                if (axi_slave_ar_valid) rd_next = R_DATA;
            end
            R_DATA: begin
                axi_slave_r_valid = 1'b1;
                axi_slave_r_last  = (r_cnt == r_len);
                if (r_dec) axi_slave_r_resp = RESP_DECERR;
                if (axi_slave_r_ready && axi_slave_r_last) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    spi_slave_axi_mem_array #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .WORDS      (MEM_WORDS)
    ) u_array (
        .clk   (axi_aclk),
        .we    (mem_we),
        .waddr (w_idx),
        .wdata (axi_slave_w_data),
        .wstrb (axi_slave_w_strb),
        .raddr (r_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_spi_slave_axi_mem.sv
// Self-checking bench for spi_slave_axi_mem: directed cases plus randomized bursts,
// checked against a plain word-array model of the memory.
module tb_spi_slave_axi_mem;
    import spi_slave_axi_mem_pkg::*;

    localparam int AW = 32, DW = 64, UW = 6, IW = 3, WORDS = 256;
`ifdef SPI_SLAVE_AXI_MEM_DECERR_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk, rst_n;
    logic aw_valid, aw_ready, aw_lock; logic [AW-1:0] aw_addr; logic [7:0] aw_len;
    logic [2:0] aw_size, aw_prot, aw_id; logic [1:0] aw_burst; logic [3:0] aw_region, aw_cache, aw_qos;
    logic [UW-1:0] aw_user, w_user, ar_user, b_user, r_user;
    logic w_valid, w_ready, w_last; logic [DW-1:0] w_data; logic [DW/8-1:0] w_strb;
    logic b_valid, b_ready; logic [1:0] b_resp; logic [IW-1:0] b_id;
    logic ar_valid, ar_ready, ar_lock; logic [AW-1:0] ar_addr; logic [7:0] ar_len;
    logic [2:0] ar_size, ar_prot, ar_id; logic [1:0] ar_burst; logic [3:0] ar_region, ar_cache, ar_qos;
    logic r_valid, r_ready, r_last; logic [DW-1:0] r_data; logic [1:0] r_resp; logic [IW-1:0] r_id;
    dbg_state_t dbg_state;

    spi_slave_axi_mem dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .axi_slave_aw_valid(aw_valid), .axi_slave_aw_ready(aw_ready), .axi_slave_aw_addr(aw_addr),
        .axi_slave_aw_len(aw_len), .axi_slave_aw_size(aw_size), .axi_slave_aw_burst(aw_burst),
        .axi_slave_aw_id(aw_id), .axi_slave_aw_prot(aw_prot), .axi_slave_aw_region(aw_region),
        .axi_slave_aw_lock(aw_lock), .axi_slave_aw_cache(aw_cache), .axi_slave_aw_qos(aw_qos),
        .axi_slave_aw_user(aw_user),
        .axi_slave_w_valid(w_valid), .axi_slave_w_ready(w_ready), .axi_slave_w_data(w_data),
        .axi_slave_w_strb(w_strb), .axi_slave_w_last(w_last), .axi_slave_w_user(w_user),
        .axi_slave_b_valid(b_valid), .axi_slave_b_ready(b_ready), .axi_slave_b_resp(b_resp),
        .axi_slave_b_id(b_id), .axi_slave_b_user(b_user),
        .axi_slave_ar_valid(ar_valid), .axi_slave_ar_ready(ar_ready), .axi_slave_ar_addr(ar_addr),
        .axi_slave_ar_len(ar_len), .axi_slave_ar_size(ar_size), .axi_slave_ar_burst(ar_burst),
        .axi_slave_ar_id(ar_id), .axi_slave_ar_prot(ar_prot), .axi_slave_ar_region(ar_region),
        .axi_slave_ar_lock(ar_lock), .axi_slave_ar_cache(ar_cache), .axi_slave_ar_qos(ar_qos),
        .axi_slave_ar_user(ar_user),
        .axi_slave_r_valid(r_valid), .axi_slave_r_ready(r_ready), .axi_slave_r_data(r_data),
        .axi_slave_r_resp(r_resp), .axi_slave_r_last(r_last), .axi_slave_r_id(r_id),
        .axi_slave_r_user(r_user), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    logic [DW-1:0]   model_mem [WORDS];
    logic [DW-1:0]   wdata_a [256];
    logic [DW/8-1:0] wstrb_a [256];
    logic [69:0]     exp_q[$];    // {data, last, id, resp} per R beat
    logic [4:0]      exp_b_q[$];  // {id, resp} per B response
    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic sig_val(input int which);
        case (which)
            0: return aw_ready;
            1: return w_ready;
            2: return b_valid;
            3: return ar_ready;
            default: return r_valid;
        endcase
    endfunction

    // Wait (bounded) until a DUT signal is high at a falling edge.
    task automatic wait_sig(input int which, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (sig_val(which)) begin
                n_checks++; n_pass++;
                break;
            end
            n++;
            if (n > 200) begin
                n_checks++;
                $display("FAIL timeout_%s: got 0 expected 1 at %0t", name, $time);
                break;
            end
        end
    endtask

    // Compare process: every R beat, every stalled R cycle and every B response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (r_valid) begin
                if (exp_q.size() == 0) check("r_unexpected", r_valid, 1'b0);
                else if (r_ready) check("r_beat", {r_data, r_last, r_id, r_resp}, exp_q.pop_front());
                else check("r_stall", {r_data, r_last, r_id, r_resp}, exp_q[0]);
            end
            if (b_valid) begin
                check("aw_ready_during_b", aw_ready, 1'b0);
                if (b_ready) begin
                    if (exp_b_q.size() == 0) check("b_unexpected", b_valid, 1'b0);
                    else check("b_resp", {b_id, b_resp}, exp_b_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                             input logic [IW-1:0] id, input int last_at, input int b_delay);
        int base, beats, idx;
        bit dec;
        logic [1:0] resp;
        base  = int'(addr[10:3]);
        dec   = DEC_EN && (addr[31:11] != 0);
        beats = ((last_at < len) ? last_at : len) + 1;
        resp  = dec ? RESP_DECERR : ((last_at != len) ? RESP_SLVERR : RESP_OKAY);
        aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_id = id; aw_valid = 1'b1;
        wait_sig(0, "aw");
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            w_data = wdata_a[b]; w_strb = wstrb_a[b]; w_last = (b == last_at); w_valid = 1'b1;
            wait_sig(1, "w");
            @(posedge clk); #1;
            if (!dec) begin
                idx = (burst == BURST_FIXED) ? base : (base + b) % WORDS;
                for (int k = 0; k < DW / 8; k++)
                    if (wstrb_a[b][k]) model_mem[idx][k*8 +: 8] = wdata_a[b][k*8 +: 8];
            end
        end
        w_valid = 1'b0; w_last = 1'b0;
        exp_b_q.push_back({id, resp});
        b_ready = 1'b0;
        for (int d = 0; d < b_delay; d++) begin
            @(negedge clk);
            check("b_valid_held", b_valid, 1'b1);
            @(posedge clk); #1;
        end
        b_ready = 1'b1;
        wait_sig(2, "b");
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input int stall_beat, input int stall_cycles);
        int base, idx;
        bit dec;
        base = int'(addr[10:3]);
        dec  = DEC_EN && (addr[31:11] != 0);
        for (int b = 0; b <= len; b++) begin
            idx = (burst == BURST_FIXED) ? base : (base + b) % WORDS;
            exp_q.push_back({dec ? 64'd0 : model_mem[idx], b == len, id, dec ? RESP_DECERR : RESP_OKAY});
        end
        ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_id = id; ar_valid = 1'b1;
        wait_sig(3, "ar");
        @(posedge clk); #1;
        ar_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (b == stall_beat) begin
                r_ready = 1'b0;
                repeat (stall_cycles) begin
                    @(negedge clk);
                    @(posedge clk); #1;
                end
            end
            r_ready = 1'b1;
            wait_sig(4, "r");
            @(posedge clk); #1;
        end
        r_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] ra;
        int len, last_at;
        logic [1:0] bu;
        rst_n = 1'b0;
        {aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_user} = '0;
        {ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_user} = '0;
        {w_valid, w_data, w_strb, w_last, w_user, b_ready, r_ready} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", aw_ready, 1'b1);   check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_w_ready", w_ready, 1'b0);     check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);     check("rst_r_last", r_last, 1'b0);
        check("rst_b_resp", b_resp, 2'b00);      check("rst_r_resp", r_resp, 2'b00);
        check("rst_b_id", b_id, 3'd0);           check("rst_r_id", r_id, 3'd0);
        check("rst_b_user", b_user, 6'd0);       check("rst_r_user", r_user, 6'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every word a known value so later reads have a defined expectation.
        for (int i = 0; i < 256; i++) begin
            wdata_a[i] = {$urandom, $urandom}; wstrb_a[i] = 8'hFF;
        end
        axi_write(32'h0, 255, BURST_INCR, 3'd1, 255, 0);

        // Single write then read.
        wdata_a[0] = 64'h1122334455667788; wstrb_a[0] = 8'hFF;
        axi_write(32'h10, 0, BURST_INCR, 3'd5, 0, 0);
        check("pin_word2", model_mem[2], 64'h1122334455667788);
        axi_read(32'h10, 0, BURST_INCR, 3'd6, -1, 0);

        // Strobed write over a zeroed word.
        wdata_a[0] = 64'd0; wstrb_a[0] = 8'hFF;
        axi_write(32'h18, 0, BURST_INCR, 3'd2, 0, 0);
        wdata_a[0] = 64'hAAAAAAAA_BBBBBBBB; wstrb_a[0] = 8'h0F;
        axi_write(32'h18, 0, BURST_INCR, 3'd2, 0, 0);
        check("pin_word3", model_mem[3], 64'h00000000_BBBBBBBB);
        axi_read(32'h18, 0, BURST_INCR, 3'd3, -1, 0);

        // INCR burst across the top of memory, with B and R backpressure.
        for (int i = 0; i < 4; i++) begin
            wdata_a[i] = {$urandom, $urandom}; wstrb_a[i] = 8'hFF;
        end
        axi_write(32'h7F8, 3, BURST_INCR, 3'd7, 3, 3);
        check("pin_word0", model_mem[0], wdata_a[1]);
        axi_read(32'h7F8, 3, BURST_INCR, 3'd4, 1, 5);

        // Early w_last on beat 2 of a 4-beat burst.
        axi_write(32'h40, 3, BURST_INCR, 3'd3, 1, 0);
        axi_read(32'h40, 3, BURST_INCR, 3'd3, -1, 0);

        // FIXED burst: all beats land on one word.
        for (int i = 0; i < 3; i++) begin
            wdata_a[i] = {$urandom, $urandom}; wstrb_a[i] = 8'(1 << i) | 8'h10;
        end
        axi_write(32'h80, 2, BURST_FIXED, 3'd0, 2, 1);
        axi_read(32'h80, 2, BURST_FIXED, 3'd0, 2, 2);

        if (DEC_EN) begin
            wdata_a[0] = 64'hDEAD_BEEF_0000_1111; wstrb_a[0] = 8'hFF;
            axi_write(32'h10000, 0, BURST_INCR, 3'd6, 0, 0);
            axi_read(32'h10000, 0, BURST_INCR, 3'd6, -1, 0);
            axi_read(32'h0, 0, BURST_INCR, 3'd1, -1, 0);
        end

        // Randomized bursts.
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, 15);
            last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
            bu = 2'($urandom_range(0, 2));
            ra = {21'd0, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7))};
            for (int i = 0; i <= len; i++) begin
                wdata_a[i] = {$urandom, $urandom}; wstrb_a[i] = 8'($urandom);
            end
            axi_write(ra, len, bu, 3'($urandom), last_at, $urandom_range(0, 2));
            ra = {21'd0, 8'($urandom_range(0, 255)), 3'd0};
            axi_read(ra, $urandom_range(0, 15), 2'($urandom_range(0, 2)), 3'($urandom),
                     $urandom_range(0, 4), $urandom_range(0, 3));
        end

        // Reset in the middle of a 4-beat write, after beat 2.
        for (int i = 0; i < 4; i++) begin
            wdata_a[i] = {$urandom, $urandom}; wstrb_a[i] = 8'hFF;
        end
        aw_addr = 32'h100; aw_len = 8'd3; aw_burst = BURST_INCR; aw_id = 3'd2; aw_valid = 1'b1;
        wait_sig(0, "aw_rst");
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w_data = wdata_a[b]; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
            wait_sig(1, "w_rst");
            @(posedge clk); #1;
            model_mem[32 + b] = wdata_a[b];
        end
        w_data = wdata_a[2];
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_w_ready", w_ready, 1'b0);  check("arst_b_valid", b_valid, 1'b0);
        check("arst_r_valid", r_valid, 1'b0);  check("arst_aw_ready", aw_ready, 1'b1);
        check("arst_ar_ready", ar_ready, 1'b1);
        w_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_aw_ready", aw_ready, 1'b1);
        check("post_rst_ar_ready", ar_ready, 1'b1);
        @(posedge clk); #1;
        axi_read(32'h100, 3, BURST_INCR, 3'd5, -1, 0);

        repeat (3) @(posedge clk);
        check("exp_r_drained", 32'(exp_q.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
